// File: rtl/ahb_bus_arbiter.sv
// Registered N-master AHB bus arbiter with fixed-priority or round-robin selection.
// Ownership is held across bursts and locked sequences, and the arbiter tracks address- and data-phase masters.
module ahb_bus_arbiter #(
  parameter int N              = 4,
  parameter int MODE           = 0,
  parameter int REVERSE        = 0,
  parameter int DEFAULT_MASTER = 0,
  localparam int LOGN          = (N > 2) ? $clog2(N) : 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [N-1:0]    HREQ,
  input  logic [N-1:0]    HLOCK,
  input  logic            HREADY,
  input  logic [1:0]      HTRANS,
  output logic [N-1:0]    HGRANT,
  output logic [LOGN-1:0] HGRANT_IDX,
  output logic            HGRANT_VALID,
  output logic [LOGN-1:0] HMASTER,
  output logic [LOGN-1:0] HMASTER_D,
  output logic            HMASTLOCK
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [LOGN-1:0] DEF_IDX    = LOGN'(DEFAULT_MASTER);
  localparam logic [N-1:0]    DEF_ONEHOT = N'(1) << DEFAULT_MASTER;

  logic [LOGN-1:0] rr_ptr;
  logic [LOGN-1:0] winner;
  logic            owner_locked;
  logic            in_burst;
  logic            arb_point;
  int              scan_idx;

  assign owner_locked = HREQ[HGRANT_IDX] & HLOCK[HGRANT_IDX];
  assign in_burst     = (HTRANS == TRANS_BUSY) || (HTRANS == TRANS_SEQ);
  assign arb_point    = HREADY && !in_burst && !owner_locked;

  // Later loop iterations override earlier ones, so each loop runs from lowest to highest priority.
  always_comb begin
    // NOTE: every variable gets a default before the loops, so no latch is inferred.
    winner   = DEF_IDX;
    scan_idx = 0;
    if (MODE == 1) begin
      for (int k = N; k >= 1; k--) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (HREQ[LOGN'(scan_idx)]) winner = LOGN'(scan_idx);
      end
    end else if (REVERSE != 0) begin
      for (int i = 0; i < N; i++) begin
        if (HREQ[LOGN'(i)]) winner = LOGN'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (HREQ[LOGN'(i)]) winner = LOGN'(i);
      end
    end
  end

  // Grant state changes only at arbitration points; it is frozen everywhere else.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANT       <= DEF_ONEHOT;
      HGRANT_IDX   <= DEF_IDX;
      HGRANT_VALID <= 1'b0;
      rr_ptr       <= DEF_IDX;
    end else if (arb_point) begin
      // NOTE: state registers use non-blocking assignments, so every flop samples values from before the edge.
      if (|HREQ) begin
        HGRANT       <= N'(1) << winner;
        HGRANT_IDX   <= winner;
        HGRANT_VALID <= 1'b1;
        rr_ptr       <= winner;
      end else begin
        HGRANT       <= DEF_ONEHOT;
        HGRANT_IDX   <= DEF_IDX;
        HGRANT_VALID <= 1'b0;
      end
    end
  end

  // The address-phase to data-phase pipeline advances only when the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      HMASTER   <= HGRANT_IDX;
      HMASTER_D <= HMASTER;
      HMASTLOCK <= owner_locked;
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter. It runs three configurations on shared stimulus.
// A per-cycle reference model checks every instance, and literal checks pin the directed scenarios.
module tb_ahb_bus_arbiter;

  localparam int N  = 4;
  localparam int NI = 3;
  // Instance 0: fixed, index 0 highest, default 2. Instance 1: fixed reversed. Instance 2: round-robin.
  localparam int CFG_MODE [NI] = '{0, 0, 1};
  localparam int CFG_REV  [NI] = '{0, 1, 0};
  localparam int CFG_DM   [NI] = '{2, 0, 0};

  logic         HCLK    = 1'b0;
  logic         HRESETn = 1'b1;
  logic [N-1:0] HREQ    = '0;
  logic [N-1:0] HLOCK   = '0;
  logic         HREADY  = 1'b1;
  logic [1:0]   HTRANS  = 2'b00;

  logic [N-1:0] grant  [NI];
  logic [1:0]   gidx   [NI];
  logic         gvalid [NI];
  logic [1:0]   mast   [NI];
  logic [1:0]   mast_d [NI];
  logic         mlock  [NI];

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(.N(N), .MODE(0), .REVERSE(0), .DEFAULT_MASTER(2)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY), .HTRANS(HTRANS),
    .HGRANT(grant[0]), .HGRANT_IDX(gidx[0]), .HGRANT_VALID(gvalid[0]),
    .HMASTER(mast[0]), .HMASTER_D(mast_d[0]), .HMASTLOCK(mlock[0])
  );

  ahb_bus_arbiter #(.N(N), .MODE(0), .REVERSE(1), .DEFAULT_MASTER(0)) u_rev (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY), .HTRANS(HTRANS),
    .HGRANT(grant[1]), .HGRANT_IDX(gidx[1]), .HGRANT_VALID(gvalid[1]),
    .HMASTER(mast[1]), .HMASTER_D(mast_d[1]), .HMASTLOCK(mlock[1])
  );

  ahb_bus_arbiter #(.N(N), .MODE(1), .REVERSE(0), .DEFAULT_MASTER(0)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .HREQ(HREQ), .HLOCK(HLOCK), .HREADY(HREADY), .HTRANS(HTRANS),
    .HGRANT(grant[2]), .HGRANT_IDX(gidx[2]), .HGRANT_VALID(gvalid[2]),
    .HMASTER(mast[2]), .HMASTER_D(mast_d[2]), .HMASTLOCK(mlock[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the priority order is listed explicitly, and the first requester in that order wins.
  typedef struct {
    int idx;
    int valid;
    int ptr;
    int mast;
    int mast_d;
    int lock;
  } model_t;

  model_t m [NI];

  function automatic int pick(input int i, input int ptr);
    int order [N];
    for (int k = 0; k < N; k++) begin
      if (CFG_MODE[i] == 1)     order[k] = (ptr + 1 + k) % N;
      else if (CFG_REV[i] != 0) order[k] = N - 1 - k;
      else                      order[k] = k;
    end
    for (int k = 0; k < N; k++) begin
      if (HREQ[2'(order[k])]) return order[k];
    end
    return CFG_DM[i];
  endfunction

  function automatic model_t reset_state(input int i);
    model_t r;
    r.idx = CFG_DM[i]; r.valid = 0; r.ptr = CFG_DM[i];
    r.mast = CFG_DM[i]; r.mast_d = CFG_DM[i]; r.lock = 0;
    return r;
  endfunction

  function automatic model_t next_state(input model_t s, input int i);
    model_t n;
    bit locked;
    bit hold;
    n      = s;
    locked = HREQ[2'(s.idx)] && HLOCK[2'(s.idx)];
    hold   = (HTRANS == 2'b01) || (HTRANS == 2'b11) || locked;
    if (HREADY) begin
      n.mast_d = s.mast;
      n.mast   = s.idx;
      n.lock   = locked ? 1 : 0;
      if (!hold) begin
        if (HREQ != '0) begin
          n.idx   = pick(i, s.ptr);
          n.valid = 1;
          n.ptr   = n.idx;
        end else begin
          n.idx   = CFG_DM[i];
          n.valid = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    for (int i = 0; i < NI; i++) begin
      if (!HRESETn) m[i] <= reset_state(i);
      else          m[i] <= next_state(m[i], i);
    end
  end

  always @(negedge HCLK) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("cmp%0d HGRANT", i),       32'(grant[i]),  32'(4'b0001 << m[i].idx));
      check($sformatf("cmp%0d HGRANT_IDX", i),   32'(gidx[i]),   32'(m[i].idx));
      check($sformatf("cmp%0d HGRANT_VALID", i), 32'(gvalid[i]), 32'(m[i].valid));
      check($sformatf("cmp%0d HMASTER", i),      32'(mast[i]),   32'(m[i].mast));
      check($sformatf("cmp%0d HMASTER_D", i),    32'(mast_d[i]), 32'(m[i].mast_d));
      check($sformatf("cmp%0d HMASTLOCK", i),    32'(mlock[i]),  32'(m[i].lock));
      check($sformatf("cmp%0d onehot", i),       32'($onehot(grant[i])), 32'd1);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HREQ    = '0;
    HLOCK   = '0;
    HTRANS  = 2'b00;
    HREADY  = 1'b1;
    tick();
    HRESETn = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 0, 1};

    // Reset state, then released with no requests pending.
    #1 HRESETn = 1'b0;
    tick();
    tick();
    check("rst grant", 32'(grant[0]), 32'h4);
    check("rst idx", 32'(gidx[0]), 32'd2);
    check("rst valid", 32'(gvalid[0]), 32'd0);
    check("rst mlock", 32'(mlock[0]), 32'd0);
    HRESETn = 1'b1;
    tick();
    tick();
    check("post-rst grant", 32'(grant[0]), 32'h4);
    check("post-rst idx", 32'(gidx[0]), 32'd2);
    check("post-rst valid", 32'(gvalid[0]), 32'd0);

    // Fixed priority in both directions.
    HREQ = 4'b1010;
    tick();
    check("fix grant", 32'(grant[0]), 32'h2);
    check("fix idx", 32'(gidx[0]), 32'd1);
    check("fix valid", 32'(gvalid[0]), 32'd1);
    check("rev grant", 32'(grant[1]), 32'h8);
    check("rev idx", 32'(gidx[1]), 32'd3);
    HREQ = 4'b0000;
    tick();
    check("idle grant", 32'(grant[0]), 32'h4);

    // Round-robin rotation from reset, including the wrap from 3 to 0, then a two-cycle stall.
    do_reset();
    HREQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr seq%0d", k), 32'(gidx[2]), 32'(exp_seq[k]));
    end
    check("rr hmaster", 32'(mast[2]), 32'd0);
    check("rr hmaster_d", 32'(mast_d[2]), 32'd3);
    HREADY = 1'b0;
    tick();
    tick();
    check("stall idx", 32'(gidx[2]), 32'd1);
    check("stall hmaster", 32'(mast[2]), 32'd0);
    check("stall hmaster_d", 32'(mast_d[2]), 32'd3);
    HREADY = 1'b1;

    // Burst hold: the owner drops its request mid-burst.
    do_reset();
    HREQ = 4'b0010;
    tick();
    check("burst own", 32'(gidx[0]), 32'd1);
    HTRANS = 2'b11;
    HREQ   = 4'b0011;
    tick();
    check("burst seq1", 32'(grant[0]), 32'h2);
    HREQ = 4'b0001;
    tick();
    check("burst seq2", 32'(grant[0]), 32'h2);
    tick();
    check("burst seq3", 32'(grant[0]), 32'h2);
    HTRANS = 2'b00;
    tick();
    check("burst end grant", 32'(grant[0]), 32'h1);

    // Locked sequence with wait states, then lock release.
    do_reset();
    HREQ = 4'b0100;
    tick();
    check("lock own", 32'(gidx[0]), 32'd2);
    HLOCK = 4'b0100;
    HREQ  = 4'b0111;
    tick();
    check("lock grant", 32'(grant[0]), 32'h4);
    check("lock mlock", 32'(mlock[0]), 32'd1);
    tick();
    check("lock grant2", 32'(grant[0]), 32'h4);
    HREADY = 1'b0;
    tick();
    tick();
    check("lock stall hmaster", 32'(mast[0]), 32'd2);
    check("lock stall hmaster_d", 32'(mast_d[0]), 32'd2);
    check("lock stall mlock", 32'(mlock[0]), 32'd1);
    HREADY = 1'b1;
    HLOCK  = 4'b0000;
    tick();
    check("unlock grant", 32'(grant[0]), 32'h1);
    check("unlock mlock", 32'(mlock[0]), 32'd0);
    tick();
    check("unlock hmaster", 32'(mast[0]), 32'd0);

    // Asynchronous reset asserted mid-burst.
    do_reset();
    HREQ = 4'b1000;
    tick();
    HTRANS = 2'b10;
    tick();
    HTRANS = 2'b11;
    tick();
    check("pre-arst grant", 32'(grant[1]), 32'h8);
    #2 HRESETn = 1'b0;
    #1;
    check("arst grant", 32'(grant[1]), 32'h1);
    check("arst idx", 32'(gidx[1]), 32'd0);
    check("arst valid", 32'(gvalid[1]), 32'd0);
    check("arst hmaster", 32'(mast[1]), 32'd0);
    check("arst hmaster_d", 32'(mast_d[1]), 32'd0);
    check("arst fix grant", 32'(grant[0]), 32'h4);
    tick();
    HRESETn = 1'b1;
    HREQ    = 4'b0000;
    HTRANS  = 2'b00;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
